pcm_to_i2s_transmitter: RTL and testbench

//  I2S bus master transmitter. It takes parallel left/right PCM sample pairs and

---
 rtl/pcm_to_i2s_transmitter.sv | 159 +++++++++++++++
 tb/tb_pcm_to_i2s_transmitter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_to_i2s_transmitter.sv
// I2S bus master transmitter: serialises buffered left/right PCM pairs into
// Philips I2S (bclk, lrclk, MSB one bclk after the lrclk edge).
module pcm_to_i2s_transmitter #(
    parameter int SAMPLE_BITS = 24,
    parameter int SLOT_BITS   = 32,
    parameter int BCLK_DIV    = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        din_valid,
    input  logic [23:0] l_pcm_data,
    input  logic [23:0] r_pcm_data,
    output logic        sample_req,
    output logic        underrun,
    output logic        overrun,
    output logic        bclk,
    output logic        lrclk,
    output logic        i2s_data
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(SLOT_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    // Stream bit k of the frame lives at index k, so the serialiser indexes by slot position.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [SAMPLE_BITS-1:0] l,
        input logic [SAMPLE_BITS-1:0] r
    );
        logic [FRAME_BITS-1:0] f;
        f = '0;
        for (int i = 0; i < SAMPLE_BITS; i++) begin
            f[i]             = l[SAMPLE_BITS-1-i];
            f[SLOT_BITS + i] = r[SAMPLE_BITS-1-i];
        end
        return f;
    endfunction

    logic [DIV_W-1:0]      div_cnt_r;
    logic [CNT_W-1:0]      bit_cnt_r;
    logic                  bclk_r;
    logic                  lrclk_r;
    logic                  data_r;
    logic                  sample_req_r;
    logic                  underrun_r;
    logic                  overrun_r;
    logic [FRAME_BITS-1:0] pend_frame_r;
    logic                  pend_full_r;
    logic                  primed_r;
    logic [FRAME_BITS-1:0] frame_r;

    logic                  tick_s;
    logic                  fall_s;
    logic                  frame_start_s;
    logic [DIV_W-1:0]      div_next_s;
    logic [CNT_W-1:0]      n_s;
    logic                  pend_full_next_s;
    logic                  primed_next_s;
    logic                  underrun_next_s;
    logic                  overrun_next_s;
    logic [FRAME_BITS-1:0] frame_next_s;
    logic                  unused_hi_s;

    // Upper port bits beyond SAMPLE_BITS are intentionally ignored.
    assign unused_hi_s = ^{l_pcm_data, r_pcm_data};

    // Bit-clock divider and next slot position.
    always_comb begin
        tick_s = (div_cnt_r == DIV_LAST);
        fall_s = tick_s & bclk_r;
        if (tick_s) begin
            div_next_s = '0;
        end else begin
            div_next_s = div_cnt_r + DIV_W'(1);
        end
        if (bit_cnt_r == CNT_LAST) begin
            n_s = '0;
        end else begin
            n_s = bit_cnt_r + CNT_W'(1);
        end
        frame_start_s = fall_s & (n_s == '0);
    end

    // Pending buffer, frame hand-over and status strobes.
    always_comb begin
        pend_full_next_s = pend_full_r;
        primed_next_s    = primed_r;
        frame_next_s     = frame_r;
        underrun_next_s  = 1'b0;
        overrun_next_s   = din_valid & pend_full_r & ~frame_start_s;
        if (frame_start_s) begin
            if (pend_full_r) begin
                frame_next_s     = pend_frame_r;
                primed_next_s    = 1'b1;
                pend_full_next_s = 1'b0;
            end else begin
                frame_next_s    = '0;
                underrun_next_s = primed_r;
            end
        end else begin
            frame_next_s = frame_r;
        end
        // A write on the frame-start edge refills the buffer after the hand-over.
        if (din_valid) begin
            pend_full_next_s = 1'b1;
        end else begin
            pend_full_next_s = pend_full_next_s;
        end
    end

    // State and output registers; bus outputs move only on bclk fall ticks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_r    <= '0;
            bit_cnt_r    <= CNT_LAST;
            bclk_r       <= 1'b0;
            lrclk_r      <= 1'b1;
            data_r       <= 1'b0;
            sample_req_r <= 1'b0;
            underrun_r   <= 1'b0;
            overrun_r    <= 1'b0;
            pend_frame_r <= '0;
            pend_full_r  <= 1'b0;
            primed_r     <= 1'b0;
            frame_r      <= '0;
        end else begin
            div_cnt_r    <= div_next_s;
            if (tick_s) begin
                bclk_r <= ~bclk_r;
            end
            if (fall_s) begin
                bit_cnt_r <= n_s;
                lrclk_r   <= (n_s >= CNT_HALF);
                data_r    <= frame_r[bit_cnt_r];
            end
            if (din_valid) begin
                pend_frame_r <= build_frame(l_pcm_data[SAMPLE_BITS-1:0],
                                            r_pcm_data[SAMPLE_BITS-1:0]);
            end
            sample_req_r <= frame_start_s;
            underrun_r   <= underrun_next_s;
            overrun_r    <= overrun_next_s;
            pend_full_r  <= pend_full_next_s;
            primed_r     <= primed_next_s;
            frame_r      <= frame_next_s;
        end
    end

    assign bclk       = bclk_r;
    assign lrclk      = lrclk_r;
    assign i2s_data   = data_r;
    assign sample_req = sample_req_r;
    assign underrun   = underrun_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_pcm_to_i2s_transmitter.sv
// Randomized bench for pcm_to_i2s_transmitter: a frame-level model predicts
// every bus bit and strobe from edge counts and the queued sample pairs.
module tb_pcm_to_i2s_transmitter;

    localparam int DIV  = 4;
    localparam int SLOT = 32;
    localparam int SB   = 24;
    localparam int FRAME_CLK = 4 * SLOT * DIV;
    localparam int DIV2  = 1;
    localparam int SLOT2 = 16;
    localparam int SB2   = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        din_valid = 1'b0;
    logic [23:0] l_pcm = 24'h0;
    logic [23:0] r_pcm = 24'h0;
    logic        sample_req, underrun, overrun, bclk, lrclk, i2s_data;
    logic        din_valid_2 = 1'b0;
    logic [23:0] l_pcm_2 = 24'h0;
    logic [23:0] r_pcm_2 = 24'h0;
    logic        sample_req_2, underrun_2, overrun_2, bclk_2, lrclk_2, i2s_data_2;

    int n_tests = 0;
    int n_fail  = 0;

    int          e;
    logic        m_full, m_primed;
    logic [47:0] m_pend;
    int          last_fs_e;
    logic [47:0] frm1 [0:255];
    logic [47:0] frm2 [0:255];
    int   obs_sr, obs_ur, obs_ov;
    logic pb1, pl1, pb2;
    int   first_rise, first_fall, last_lr_fall, lr_period, last_rise2, period2;
    logic [1:0] rxq [$];

    pcm_to_i2s_transmitter #(.SAMPLE_BITS(SB), .SLOT_BITS(SLOT), .BCLK_DIV(DIV)) dut (
        .clk(clk), .reset_n(reset_n), .din_valid(din_valid),
        .l_pcm_data(l_pcm), .r_pcm_data(r_pcm),
        .sample_req(sample_req), .underrun(underrun), .overrun(overrun),
        .bclk(bclk), .lrclk(lrclk), .i2s_data(i2s_data)
    );

    pcm_to_i2s_transmitter #(.SAMPLE_BITS(SB2), .SLOT_BITS(SLOT2), .BCLK_DIV(DIV2)) dut2 (
        .clk(clk), .reset_n(reset_n), .din_valid(din_valid_2),
        .l_pcm_data(l_pcm_2), .r_pcm_data(r_pcm_2),
        .sample_req(sample_req_2), .underrun(underrun_2), .overrun(overrun_2),
        .bclk(bclk_2), .lrclk(lrclk_2), .i2s_data(i2s_data_2)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, e, got, exp);
        end
    endtask

    function automatic logic [47:0] frame_of(input int inst, input int f);
        if (f < 0 || f > 255) return 48'h0;
        return (inst == 1) ? frm1[f] : frm2[f];
    endfunction

    // Bit k of a frame: left slot then right slot, each MSB-first then zero padding.
    function automatic logic stream_bit(input logic [47:0] pair, input int k, input int slot, input int sb);
        logic [23:0] smp;
        int p;
        smp = (k >= slot) ? pair[23:0] : pair[47:24];
        p = k % slot;
        if (p >= sb) return 1'b0;
        return smp[sb-1-p];
    endfunction

    // Expected {bclk, lrclk, data} after ee clock edges since reset release.
    function automatic logic [2:0] exp_bus(input int ee, input int div, input int slot, input int sb, input int inst);
        int m, n, f;
        logic b, lr, d;
        b = ((ee / div) % 2) == 1;
        m = ee / (2 * div);
        if (m == 0) return {b, 1'b1, 1'b0};
        n  = (m - 1) % (2 * slot);
        f  = (m - 1) / (2 * slot);
        lr = (n >= slot);
        if (n == 0) d = stream_bit(frame_of(inst, f - 1), 2 * slot - 1, slot, sb);
        else        d = stream_bit(frame_of(inst, f), n - 1, slot, sb);
        return {b, lr, d};
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        din_valid = 1'b0;
        din_valid_2 = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst", 64'({bclk, lrclk, i2s_data, sample_req, underrun, overrun}), 64'(6'b010000));
        check_val("rst2", 64'({bclk_2, lrclk_2, i2s_data_2}), 64'(3'b010));
        e = 0; m_full = 1'b0; m_primed = 1'b0; m_pend = 48'h0; last_fs_e = -1000;
        for (int i = 0; i < 256; i++) begin
            frm1[i] = 48'h0;
            frm2[i] = 48'h0;
        end
        obs_sr = 0; obs_ur = 0; obs_ov = 0;
        pb1 = 1'b0; pl1 = 1'b1; pb2 = 1'b0;
        first_rise = -1; first_fall = -1; last_lr_fall = -1; lr_period = -1;
        last_rise2 = -1; period2 = -1;
        rxq.delete();
        reset_n = 1'b1;
    endtask

    // One clock: drive at the falling edge, advance the model, check 1 time unit after the rise.
    task automatic cycle(input logic dv, input logic [23:0] l, input logic [23:0] r);
        logic fs;
        logic [5:0] exp1;
        logic [2:0] exp2;
        int fi;
        din_valid = dv; l_pcm = l; r_pcm = r;
        e = e + 1;
        fs = (e >= 2 * DIV) && (((e - 2 * DIV) % FRAME_CLK) == 0);
        exp1[2] = fs;
        exp1[1] = fs && !m_full && m_primed;
        exp1[0] = dv && m_full && !fs;
        if (fs) begin
            fi = (e - 2 * DIV) / FRAME_CLK;
            if (fi < 256) frm1[fi] = m_full ? m_pend : 48'h0;
            if (m_full) m_primed = 1'b1;
            m_full = 1'b0;
            last_fs_e = e;
        end
        if (dv) begin
            m_pend = {l, r};
            m_full = 1'b1;
        end
        exp1[5:3] = exp_bus(e, DIV, SLOT, SB, 1);
        exp2      = exp_bus(e, DIV2, SLOT2, SB2, 2);
        @(posedge clk);
        #1;
        check_val("bus", 64'({bclk, lrclk, i2s_data, sample_req, underrun, overrun}), 64'(exp1));
        check_val("bus2", 64'({bclk_2, lrclk_2, i2s_data_2}), 64'(exp2));
        if (sample_req) obs_sr++;
        if (underrun)   obs_ur++;
        if (overrun)    obs_ov++;
        if (bclk && !pb1) begin
            rxq.push_back({lrclk, i2s_data});
            if (first_rise < 0) first_rise = e;
        end
        if (!bclk && pb1 && first_fall < 0) first_fall = e;
        if (!lrclk && pl1) begin
            if (last_lr_fall >= 0) lr_period = e - last_lr_fall;
            last_lr_fall = e;
        end
        if (bclk_2 && !pb2) begin
            if (last_rise2 >= 0) period2 = e - last_rise2;
            last_rise2 = e;
        end
        pb1 = bclk; pl1 = lrclk; pb2 = bclk_2;
        @(negedge clk);
    endtask

    initial begin
        int k, idx;
        logic [23:0] base_l, base_r;
        logic [31:0] lw, rw;
        logic [47:0] p, q;
        logic found;

        // T1: reset values, first bclk edges, asynchronous reset mid-frame
        do_reset();
        cycle(1'b1, 24'($urandom), 24'($urandom));
        repeat (299) cycle(1'b0, 24'($urandom), 24'($urandom));
        check_val("t1_first_rise", 64'(first_rise), 64'(4));
        check_val("t1_first_fall", 64'(first_fall), 64'(8));
        #2 reset_n = 1'b0;
        #1;
        check_val("t1_async_rst", 64'({bclk, lrclk, i2s_data, sample_req, underrun, overrun}), 64'(6'b010000));
        check_val("t1_async_rst2", 64'({bclk_2, lrclk_2, i2s_data_2}), 64'(3'b010));

        // T2: fixed pattern decoded by a bclk-rise receiver
        do_reset();
        cycle(1'b1, 24'hA5C3F0, 24'h0F1E2D);
        while (e < 1100) cycle(1'b0, 24'($urandom), 24'($urandom));
        found = 1'b0;
        idx = 0;
        for (int i = 1; i < rxq.size(); i++) begin
            if (!found && rxq[i][1] == 1'b0 && rxq[i-1][1] == 1'b1) begin
                found = 1'b1;
                idx = i;
            end
        end
        check_val("t2_rx_found", 64'(found && (idx + 64 < rxq.size())), 64'(1));
        lw = 32'h0;
        rw = 32'h0;
        if (found && (idx + 64 < rxq.size())) begin
            for (int j = 1; j <= 32; j++)  lw = {lw[30:0], rxq[idx+j][0]};
            for (int j = 33; j <= 64; j++) rw = {rw[30:0], rxq[idx+j][0]};
        end
        check_val("t2_left", 64'(lw), 64'({24'hA5C3F0, 8'h00}));
        check_val("t2_right", 64'(rw), 64'({24'h0F1E2D, 8'h00}));
        check_val("t2_lr_period", 64'(lr_period), 64'(512));

        // T3: answer every frame start 10 clk later with a ramp for 100 frames
        do_reset();
        k = 0;
        base_l = 24'($urandom);
        base_r = 24'($urandom);
        while (e < 2 * DIV + 100 * FRAME_CLK + 20) begin
            if (e + 1 == last_fs_e + 10) begin
                cycle(1'b1, base_l + 24'(k), base_r - 24'(k));
                k++;
            end else begin
                cycle(1'b0, 24'($urandom), 24'($urandom));
            end
        end
        check_val("t3_underrun", 64'(obs_ur), 64'(0));
        check_val("t3_overrun", 64'(obs_ov), 64'(0));
        check_val("t3_sample_req", 64'(obs_sr), 64'(101));

        // T4: one pair after a silent first frame, then starvation
        do_reset();
        while (e < 2 * DIV + 5 * FRAME_CLK + 20)
            cycle(e + 1 == 100, 24'($urandom), 24'($urandom));
        check_val("t4_underrun", 64'(obs_ur), 64'(4));

        // T5: overrun, empty-buffer collision, full-buffer collision
        do_reset();
        while (e < 2600) begin
            if (e + 1 == 1 || e + 1 == 3 || e + 1 == 520 || e + 1 == 1100 || e + 1 == 1544)
                cycle(1'b1, 24'($urandom), 24'($urandom));
            else
                cycle(1'b0, 24'($urandom), 24'($urandom));
        end
        check_val("t5_overrun", 64'(obs_ov), 64'(1));
        check_val("t5_underrun", 64'(obs_ur), 64'(2));
        check_val("t5_sample_req", 64'(obs_sr), 64'(6));

        // T6: 16-bit slots, BCLK_DIV=1 on the second instance
        do_reset();
        p = {24'($urandom), 24'($urandom)};
        q = {24'($urandom), 24'($urandom)};
        frm2[0] = p;
        frm2[1] = q;
        for (int c = 1; c <= 200; c++) begin
            din_valid_2 = (c == 1) || (c == 10);
            {l_pcm_2, r_pcm_2} = (c == 10) ? q : p;
            cycle(1'b0, 24'($urandom), 24'($urandom));
            if (e == 66)  check_val("t6_rlsb_p", 64'(i2s_data_2), 64'(p[0]));
            if (e == 130) check_val("t6_rlsb_q", 64'(i2s_data_2), 64'(q[0]));
        end
        din_valid_2 = 1'b0;
        check_val("t6_bclk_period", 64'(period2), 64'(2));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
